psum_accum_buf: RTL and testbench

PSUM_ACCUM_BUF -- requirements
Module: psum_accum_buf

---
 rtl/psum_accum_buf.sv | 108 ++++++++++
 tb/tb_psum_accum_buf.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_buf.sv
// psum_accum_buf: multi-pass saturating partial-sum accumulator with a ready/valid drain port.
// Define PSUM_RELU_EN to clamp negative results to zero on out_data (accumulator contents unchanged).
module psum_accum_buf #(
  parameter int PSUM_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            tile_len_m1,
  input  logic [3:0]            num_pass_m1,
  input  logic                  psum_valid,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_protocol
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(DEPTH);
  localparam logic [3:0] LEN_MAX = 4'(DEPTH - 1);
  localparam logic [PSUM_WIDTH-1:0] SAT_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] SAT_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t r_state;
  logic [3:0] r_len, r_npass, r_pass, r_wr_idx, r_rd_idx;
  logic [PSUM_WIDTH-1:0] r_mem [DEPTH];
  logic r_out_valid, r_busy, r_done, r_err_ovf, r_err_prot;
  logic w_acc, w_last_entry, w_ovf;
  logic [PSUM_WIDTH:0] w_sum;
  logic [PSUM_WIDTH-1:0] w_entry, w_wr_data, w_rd_data;

  assign w_acc        = (r_state == ACCUM) && psum_valid;
  assign w_last_entry = r_wr_idx == r_len;
  assign w_entry      = r_mem[r_wr_idx[AW-1:0]];
  assign w_sum        = {w_entry[PSUM_WIDTH-1], w_entry} + {psum_in[PSUM_WIDTH-1], psum_in};
  // Pass 0 overwrites, so an overflow can only come from a later pass.
  assign w_ovf        = (r_pass != 4'd0) && (w_sum[PSUM_WIDTH] != w_sum[PSUM_WIDTH-1]);
  assign w_wr_data    = (r_pass == 4'd0) ? psum_in :
                        w_ovf ? (w_sum[PSUM_WIDTH] ? SAT_MIN : SAT_MAX) : w_sum[PSUM_WIDTH-1:0];
  assign w_rd_data    = r_mem[r_rd_idx[AW-1:0]];

`ifdef PSUM_RELU_EN
  assign out_data = (r_out_valid && !w_rd_data[PSUM_WIDTH-1]) ? w_rd_data : '0;
`else
  assign out_data = r_out_valid ? w_rd_data : '0;
`endif

  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_overflow = r_err_ovf;
  assign err_protocol = r_err_prot;

  always_ff @(posedge clk)
    if (w_acc) r_mem[r_wr_idx[AW-1:0]] <= w_wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_len       <= 4'd0;
      r_npass     <= 4'd0;
      r_pass      <= 4'd0;
      r_wr_idx    <= 4'd0;
      r_rd_idx    <= 4'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_prot  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state    <= ACCUM;
          r_busy     <= 1'b1;
          r_len      <= ({1'b0, tile_len_m1} >= DEPTH5) ? LEN_MAX : tile_len_m1;
          r_npass    <= num_pass_m1;
          r_wr_idx   <= 4'd0;
          r_pass     <= 4'd0;
          r_err_ovf  <= 1'b0;
          r_err_prot <= 1'b0;
        end
        ACCUM: if (psum_valid) begin
          if (w_ovf) r_err_ovf <= 1'b1;
          r_wr_idx <= w_last_entry ? 4'd0 : r_wr_idx + 4'd1;
          if (w_last_entry && r_pass == r_npass) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_rd_idx    <= 4'd0;
          end else if (w_last_entry) r_pass <= r_pass + 4'd1;
        end
        DRAIN: if (out_ready) begin
          if (r_rd_idx == r_len) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else r_rd_idx <= r_rd_idx + 4'd1;
        end
        default: r_state <= IDLE;
      endcase
      if (psum_valid && r_state != ACCUM) r_err_prot <= 1'b1;
    end
endmodule

// File: tb/tb_psum_accum_buf.sv
// tb_psum_accum_buf: directed scoreboard bench for psum_accum_buf (DEPTH=16 and a DEPTH=8 instance).
module tb_psum_accum_buf;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, psum_valid = 1'b0, out_ready = 1'b0, sel = 1'b0;
  logic [3:0] tile_len_m1 = 4'd0, num_pass_m1 = 4'd0;
  logic [15:0] psum_in = 16'd0;
  logic ov16, bz16, dn16, eo16, ep16, ov8, bz8, dn8, eo8, ep8;
  logic [15:0] od16, od8;
  logic out_valid, busy, done, err_overflow, err_protocol;
  logic [15:0] out_data;
  logic [15:0] q[$];
  logic [15:0] m[16];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  psum_accum_buf #(.PSUM_WIDTH(16), .DEPTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .tile_len_m1(tile_len_m1),
    .num_pass_m1(num_pass_m1), .psum_valid(psum_valid & ~sel), .psum_in(psum_in),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .busy(bz16), .done(dn16),
    .err_overflow(eo16), .err_protocol(ep16));

  psum_accum_buf #(.PSUM_WIDTH(16), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .tile_len_m1(tile_len_m1),
    .num_pass_m1(num_pass_m1), .psum_valid(psum_valid & sel), .psum_in(psum_in),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .busy(bz8), .done(dn8),
    .err_overflow(eo8), .err_protocol(ep8));

  assign out_valid    = sel ? ov8 : ov16;
  assign out_data     = sel ? od8 : od16;
  assign busy         = sel ? bz8 : bz16;
  assign done         = sel ? dn8 : dn16;
  assign err_overflow = sel ? eo8 : eo16;
  assign err_protocol = sel ? ep8 : ep16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : 16'(s);
  endfunction

  function automatic logic [15:0] post(input logic [15:0] v);
`ifdef PSUM_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic do_start(input logic [3:0] len, input logic [3:0] np);
    tile_len_m1 = len;
    num_pass_m1 = np;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    psum_valid = 1'b1;
    psum_in = v;
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  // Pops one expectation per output transfer; optionally stalls the consumer for 3 cycles.
  task automatic drain(input int n, input int hold_idx);
    logic [15:0] e;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (out_valid !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("drain_valid", out_valid, 1);
      e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
      chk("drain_data", out_data, e);
      if (k == hold_idx) repeat (3) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("sb_empty", q.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_prot", err_protocol, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-pass basic accumulation with backpressure at entry 1
    do_start(4'd3, 4'd1);
    chk("busy_accum", busy, 1);
    send(16'h1000); send(16'h0800); send(16'hFC00); send(16'h0000);
    send(16'h1000); send(16'h0800); send(16'h0100); send(16'h0005);
    chk("first_valid", out_valid, 1);
    q.push_back(16'h2000);
    q.push_back(16'h1000);
`ifdef PSUM_RELU_EN
    q.push_back(16'h0000);
`else
    q.push_back(16'hFD00);
`endif
    q.push_back(16'h0005);
    drain(4, 1);
    chk("basic_ovf", err_overflow, 0);
    chk("basic_prot", err_protocol, 0);

    // Positive and negative saturation
    do_start(4'd0, 4'd1);
    send(16'h7000); send(16'h2000);
    q.push_back(16'h7FFF);
    drain(1, -1);
    chk("sat_pos_ovf", err_overflow, 1);
    do_start(4'd0, 4'd1);
    chk("start_clr_ovf", err_overflow, 0);
    send(16'h9000); send(16'hE000);
`ifdef PSUM_RELU_EN
    q.push_back(16'h0000);
`else
    q.push_back(16'h8000);
`endif
    drain(1, -1);
    chk("sat_neg_ovf", err_overflow, 1);

    // Asynchronous reset mid pass 1, then protocol error and a fresh single-pass tile
    do_start(4'd3, 4'd1);
    send(16'h0100); send(16'h0200); send(16'h0300); send(16'h0400);
    send(16'h0700); send(16'h0700);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", err_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h1234);
    chk("idle_prot", err_protocol, 1);
    chk("idle_discard", out_valid, 0);
    do_start(4'd3, 4'd0);
    chk("start_clr_prot", err_protocol, 0);
    send(16'h0111); send(16'h0222); send(16'h7FFF); send(16'h0001);
    send(16'h5555);
    chk("drain_prot", err_protocol, 1);
    q.push_back(16'h0111); q.push_back(16'h0222); q.push_back(16'h7FFF); q.push_back(16'h0001);
    drain(4, 2);

    // Full 16-entry, 3-pass tile with gaps and stray starts in ACCUM and DRAIN
    do_start(4'd15, 4'd2);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 16; i++) begin
        logic [15:0] v;
        v = 16'($urandom_range(0, 65535));
        m[i] = (p == 0) ? v : sat(m[i], v);
        send(v);
        if (p == 2 && i == 15) begin end
        else if (i == 5 || i == 11) do_start(4'd2, 4'd0);
        else @(negedge clk);
      end
    chk("gap_valid", out_valid, 1);
    do_start(4'd2, 4'd0);
    for (int i = 0; i < 16; i++) q.push_back(post(m[i]));
    drain(16, 7);

    // DEPTH=8 instance clamps tile_len_m1=15 to 8 entries
    sel = 1'b1;
    @(negedge clk);
    do_start(4'd15, 4'd0);
    for (int i = 0; i < 8; i++) begin
      send(16'(i * 16'h0111 + 1));
      q.push_back(16'(i * 16'h0111 + 1));
    end
    chk("d8_valid", out_valid, 1);
    drain(8, -1);
    repeat (3) @(negedge clk);
    chk("d8_no_extra", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
